// File: rtl/hazard_mc_pkg.sv
// Shared encodings for the hazard unit: forwarding selects, MCycle FSM states, PC address.
package hazard_mc_pkg;

   localparam int unsigned FWD_SEL_W = 2;

   // Execute-stage operand source selects
   localparam logic [FWD_SEL_W-1:0] FWD_RF = 2'b00;
   localparam logic [FWD_SEL_W-1:0] FWD_W  = 2'b01;
   localparam logic [FWD_SEL_W-1:0] FWD_M  = 2'b10;

   // Register address of the PC for the default 4-bit register file
   localparam int unsigned REG_A_W = 4;
   localparam logic [REG_A_W-1:0] REG_PC = 4'hF;

   // MCycle sequencer states
   typedef enum logic [0:0] {
      MC_IDLE = 1'b0,
      MC_BUSY = 1'b1
   } mc_state_t;

endpackage : hazard_mc_pkg

// File: rtl/hazard_mc_seq.sv
// MCycle (MUL/DIV) stall sequencer: IDLE/BUSY FSM, fixed-latency counter and done latch.
// Outputs are combinational so the stall reaches the pipeline in the same cycle.
module hazard_mc_seq
   import hazard_mc_pkg::*;
#(
   parameter int unsigned MC_LATENCY = 0,
   parameter int unsigned CNT_W      = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic mc_start_e,
   input  logic mc_done,
   input  logic mem_stall,
   output logic mc_stall_c,
   output logic mc_start_c
);

   // Fixed-latency mode ignores the done handshake entirely
   localparam bit FIXED = (MC_LATENCY != 0);
   localparam logic [CNT_W-1:0] CNT_LOAD = FIXED ? CNT_W'(MC_LATENCY - 1) : '0;

   mc_state_t        state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic             done_q, done_nx;
   logic             release_c;
   logic             start_ok_c;

   // The MCycle unit reports completion (count expired or done seen now/earlier)
   always_comb begin
      release_c = 1'b0;
      if (FIXED) begin
         release_c = (cnt == '0);
      end else begin
         release_c = mc_done | done_q;
      end
   end

   // A new operation is launched only when memory is not holding the pipeline
   always_comb begin
      start_ok_c = mc_start_e & ~mem_stall;
   end

   // State, counter and done-latch registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= MC_IDLE;
         cnt    <= '0;
         done_q <= 1'b0;
      end else begin
         state  <= state_nx;
         cnt    <= cnt_nx;
         done_q <= done_nx;
      end
   end

   // Next-state: counter keeps running under a memory stall, but BUSY is only left once
   // the pipeline can actually release E; a done seen meanwhile is held until then.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      done_nx  = done_q;
      case (state)
         MC_IDLE: begin
            if (start_ok_c) begin
               state_nx = MC_BUSY;
               cnt_nx   = CNT_LOAD;
               done_nx  = 1'b0;
            end
         end
         MC_BUSY: begin
            if (cnt != '0) begin
               cnt_nx = cnt - 1'b1;
            end
            if (release_c && !mem_stall) begin
               state_nx = MC_IDLE;
               done_nx  = 1'b0;
            end else if (!FIXED && mc_done) begin
               done_nx = 1'b1;
            end
         end
         default: begin
            state_nx = MC_IDLE;
            cnt_nx   = '0;
            done_nx  = 1'b0;
         end
      endcase
   end

   // Outputs: start cycle stalls and pulses; BUSY stalls until release
   always_comb begin
      mc_stall_c = 1'b0;
      mc_start_c = 1'b0;
      case (state)
         MC_IDLE: begin
            mc_stall_c = start_ok_c;
            mc_start_c = start_ok_c;
         end
         MC_BUSY: begin
            mc_stall_c = ~release_c;
         end
         default: begin
            mc_stall_c = 1'b0;
            mc_start_c = 1'b0;
         end
      endcase
   end

endmodule : hazard_mc_seq

// File: rtl/hazard_mc.sv
// Pipeline hazard unit for the 5-stage ARM core: forwarding, LDR-use stall, branch flush,
// MCycle stall sequencing and memory wait-state stall. All outputs are combinational.
module hazard_mc
   import hazard_mc_pkg::*;
#(
   parameter int unsigned RA_W       = 4,
   parameter int unsigned MC_LATENCY = 0,
   parameter int unsigned CNT_W      = 4
) (
   input  logic            CLK,
   input  logic            Reset,
   input  logic [RA_W-1:0] RA1D,
   input  logic [RA_W-1:0] RA2D,
   input  logic [RA_W-1:0] RA1E,
   input  logic [RA_W-1:0] RA2E,
   input  logic [RA_W-1:0] WA3E,
   input  logic            RegWriteE,
   input  logic            MemtoRegE,
   input  logic            PCSrcE,
   input  logic            McStartE,
   input  logic            McDone,
   input  logic [RA_W-1:0] WA3M,
   input  logic [RA_W-1:0] RA2M,
   input  logic            RegWriteM,
   input  logic            MemWriteM,
   input  logic            MemtoRegM,
   input  logic            MemReadyM,
   input  logic [RA_W-1:0] WA3W,
   input  logic            RegWriteW,
   input  logic            MemtoRegW,
   output logic            McStart,
   output logic            StallF,
   output logic            StallD,
   output logic            StallE,
   output logic            StallM,
   output logic            FlushD,
   output logic            FlushE,
   output logic            FlushM,
   output logic            FlushW,
   output logic [1:0]      ForwardAE,
   output logic [1:0]      ForwardBE,
   output logic            ForwardM
);

   logic mem_stall_c;
   logic ldr_stall_c;
   logic mc_stall_c;
   logic mc_start_c;
   logic pc_a_e_c, pc_b_e_c, pc_a_d_c, pc_b_d_c;

   // PC (all-ones address) is never a forwarding or interlock source
   always_comb begin
      pc_a_e_c = &RA1E;
      pc_b_e_c = &RA2E;
      pc_a_d_c = &RA1D;
      pc_b_d_c = &RA2D;
   end

   // Memory wait state and load-use interlock conditions
   always_comb begin
      mem_stall_c = (MemtoRegM | MemWriteM) & ~MemReadyM;
      ldr_stall_c = MemtoRegE & RegWriteE &
                    (((RA1D == WA3E) & ~pc_a_d_c) | ((RA2D == WA3E) & ~pc_b_d_c));
   end

   hazard_mc_seq #(
      .MC_LATENCY (MC_LATENCY),
      .CNT_W      (CNT_W)
   ) u_seq (
      .clk        (CLK),
      .reset      (Reset),
      .mc_start_e (McStartE),
      .mc_done    (McDone),
      .mem_stall  (mem_stall_c),
      .mc_stall_c (mc_stall_c),
      .mc_start_c (mc_start_c)
   );

   // Operand forwarding for E (M has priority over W) and W->M store-data forwarding
   always_comb begin
      ForwardAE = FWD_RF;
      ForwardBE = FWD_RF;
      ForwardM  = 1'b0;
      if (!Reset) begin
         if (!pc_a_e_c) begin
            if (RegWriteM && (RA1E == WA3M)) begin
               ForwardAE = FWD_M;
            end else if (RegWriteW && (RA1E == WA3W)) begin
               ForwardAE = FWD_W;
            end
         end
         if (!pc_b_e_c) begin
            if (RegWriteM && (RA2E == WA3M)) begin
               ForwardBE = FWD_M;
            end else if (RegWriteW && (RA2E == WA3W)) begin
               ForwardBE = FWD_W;
            end
         end
         ForwardM = (RA2M == WA3W) & MemWriteM & MemtoRegW & RegWriteW;
      end
   end

   // Stall/flush arbitration: reset, memory wait, MCycle, load-use, then branch.
   // A branch held in a stalled E keeps PCSrcE asserted, so its flush lands on release.
   always_comb begin
      McStart = 1'b0;
      StallF  = 1'b0;
      StallD  = 1'b0;
      StallE  = 1'b0;
      StallM  = 1'b0;
      FlushD  = 1'b0;
      FlushE  = 1'b0;
      FlushM  = 1'b0;
      FlushW  = 1'b0;
      if (Reset) begin
         FlushD = 1'b1;
         FlushE = 1'b1;
         FlushM = 1'b1;
         FlushW = 1'b1;
      end else if (mem_stall_c) begin
         StallF = 1'b1;
         StallD = 1'b1;
         StallE = 1'b1;
         StallM = 1'b1;
         FlushW = 1'b1;
      end else if (mc_stall_c) begin
         McStart = mc_start_c;
         StallF  = 1'b1;
         StallD  = 1'b1;
         StallE  = 1'b1;
         FlushM  = 1'b1;
      end else if (ldr_stall_c) begin
         StallF = 1'b1;
         StallD = 1'b1;
         FlushE = 1'b1;
      end else if (PCSrcE) begin
         FlushD = 1'b1;
         FlushE = 1'b1;
      end
   end

endmodule : hazard_mc
